// File: rtl/gate_vector_checker_if.sv
// Bus bundle for gate_vector_checker: run control, gate-stage vector input
// and the run result outputs.
//
// Handshake: a vector (a, b, gate_out) transfers on a rising clk edge where
// in_valid and in_ready are both 1. in_ready is a registered decode of the
// checker's RUN state and never depends on in_valid. Vectors offered while
// in_ready is 0 are dropped. The master may hold in_valid high across
// consecutive cycles to stream one vector per cycle.
interface gate_vector_checker_if;
  logic       start;
  logic       in_valid;
  logic       a;
  logic       b;
  logic [6:0] gate_out;
  logic       in_ready;
  logic       done;
  logic       pass;
  logic [3:0] err_cnt;
  logic [2:0] vec_cnt;
  logic [6:0] err_mask;

  modport master (
    output start, in_valid, a, b, gate_out,
    input  in_ready, done, pass, err_cnt, vec_cnt, err_mask
  );

  modport slave (
    input  start, in_valid, a, b, gate_out,
    output in_ready, done, pass, err_cnt, vec_cnt, err_mask
  );
endinterface

// File: rtl/gate_vector_checker.sv
// gate_vector_checker: checks NUM_VEC gate-stage vectors per run against the
// expected {AND, OR, XOR, XNOR, NAND, NOT a, NOT b} of operands a and b,
// counts mismatching vectors and input-pair coverage, and reports a verdict.
//
// Optional feature: define GATE_VECTOR_CHECKER_ERR_MASK_EN to keep a sticky
// per-gate failure mask in err_mask; otherwise err_mask is tied to zero and
// no mask flops exist.
//
// dbg_state exposes the FSM state (0=IDLE, 1=RUN, 2=DONE) for observation.
module gate_vector_checker #(
  parameter int NUM_VEC = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gate_vector_checker_if.slave  bus,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] LAST_VEC = 3'(NUM_VEC);
  // Full input-pair coverage is only achievable with at least four vectors.
  localparam bit COV_REQ = (NUM_VEC >= 4);

  state_e     state_q, state_d;
  logic       in_ready_q, in_ready_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] err_cnt_q, err_cnt_d;
  logic [2:0] vec_cnt_q, vec_cnt_d;
  logic [3:0] cov_q, cov_d;

  logic       accept;
  logic       start_take;
  logic [6:0] exp_gates;
  logic [6:0] mismatch;
  logic       cov_ok;

  // in_ready_q is high exactly in RUN, so it also gates acceptance; in DONE
  // it is low, which is why start+in_valid there takes only the start.
  assign accept     = bus.in_valid & in_ready_q;
  assign start_take = bus.start & (state_q != RUN);
  assign exp_gates  = {bus.a & bus.b, bus.a | bus.b, bus.a ^ bus.b,
                       ~(bus.a ^ bus.b), ~(bus.a & bus.b), ~bus.a, ~bus.b};
  assign mismatch   = exp_gates ^ bus.gate_out;

  // Next-state, counters, coverage and registered output decode.
  always_comb begin
    state_d   = state_q;
    err_cnt_d = err_cnt_q;
    vec_cnt_d = vec_cnt_q;
    cov_d     = cov_q;
    if (start_take) begin
      state_d   = RUN;
      err_cnt_d = 4'd0;
      vec_cnt_d = 3'd0;
      cov_d     = 4'd0;
    end else if (accept) begin
      vec_cnt_d = vec_cnt_q + 3'd1;
      if ((mismatch != 7'd0) && (err_cnt_q != 4'hF)) begin
        err_cnt_d = err_cnt_q + 4'd1;
      end
      cov_d = cov_q | (4'b0001 << {bus.a, bus.b});
      if (vec_cnt_q + 3'd1 == LAST_VEC) begin
        state_d = DONE;
      end
    end
    cov_ok     = !COV_REQ || (cov_d == 4'hF);
    in_ready_d = (state_d == RUN);
    done_d     = (state_d == DONE);
    pass_d     = (state_d == DONE) && (err_cnt_d == 4'd0) && cov_ok;
  end

  // State and all result registers; reset aborts any run with no verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= 4'd0;
      vec_cnt_q  <= 3'd0;
      cov_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_cnt_q  <= err_cnt_d;
      vec_cnt_q  <= vec_cnt_d;
      cov_q      <= cov_d;
    end
  end

`ifdef GATE_VECTOR_CHECKER_ERR_MASK_EN
  logic [6:0] err_mask_q, err_mask_d;

  // Sticky per-gate failure bits, cleared by a run start.
  always_comb begin
    err_mask_d = err_mask_q;
    if (start_take) begin
      err_mask_d = 7'd0;
    end else if (accept) begin
      err_mask_d = err_mask_q | mismatch;
    end
  end

  // Mask register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_mask_q <= 7'd0;
    end else begin
      err_mask_q <= err_mask_d;
    end
  end

  assign bus.err_mask = err_mask_q;
`else
  assign bus.err_mask = 7'd0;
`endif

  assign bus.in_ready = in_ready_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.vec_cnt  = vec_cnt_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Testbench for gate_vector_checker: one NUM_VEC=4 instance and one NUM_VEC=7
// instance. Expected run verdicts are queued when a run is issued and a
// monitor pops and compares them whenever done rises.
module tb_gate_vector_checker;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gate_vector_checker_if ifc4 ();
  gate_vector_checker_if ifc7 ();
  logic [1:0] dbg4, dbg7;

  gate_vector_checker #(.NUM_VEC(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(ifc4.slave), .dbg_state(dbg4)
  );
  gate_vector_checker #(.NUM_VEC(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .bus(ifc7.slave), .dbg_state(dbg7)
  );

`ifdef GATE_VECTOR_CHECKER_ERR_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  // Hand-computed correct gate_out per (a,b): {AND,OR,XOR,XNOR,NAND,~a,~b}
  localparam logic [6:0] G00 = 7'b0001111;
  localparam logic [6:0] G01 = 7'b0110110;
  localparam logic [6:0] G10 = 7'b0110101;
  localparam logic [6:0] G11 = 7'b1101000;

  localparam int W = 15; // {pass, err_cnt[3:0], vec_cnt[2:0], err_mask[6:0]}
  logic [W-1:0] exp4_q[$];
  logic [W-1:0] exp7_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int sel = 0; // 0 drives dut4, 1 drives dut7
  logic done4_prev = 1'b0;
  logic done7_prev = 1'b0;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pk(input logic p, input logic [3:0] e,
                                      input logic [2:0] v, input logic [6:0] m);
    return {p, e, v, (MASK_EN ? m : 7'd0)};
  endfunction

  function automatic logic rdy();
    return (sel == 0) ? ifc4.in_ready : ifc7.in_ready;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic v, input logic a,
                       input logic b, input logic [6:0] g);
    if (sel == 0) begin
      ifc4.start = s; ifc4.in_valid = v; ifc4.a = a; ifc4.b = b; ifc4.gate_out = g;
    end else begin
      ifc7.start = s; ifc7.in_valid = v; ifc7.a = a; ifc7.b = b; ifc7.gate_out = g;
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_vec(input logic a, input logic b, input logic [6:0] g);
    bit ok = 1'b0;
    drive(1'b0, 1'b1, a, b, g);
    for (int i = 0; i < 10; i++) begin
      if (rdy()) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("handshake_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (ifc4.done && !done4_prev) begin
      if (exp4_q.size() == 0) check("unexpected_done4", 32'd1, 32'd0);
      else check("verdict4", 32'({ifc4.pass, ifc4.err_cnt, ifc4.vec_cnt, ifc4.err_mask}),
                 32'(exp4_q.pop_front()));
    end
    if (ifc7.done && !done7_prev) begin
      if (exp7_q.size() == 0) check("unexpected_done7", 32'd1, 32'd0);
      else check("verdict7", 32'({ifc7.pass, ifc7.err_cnt, ifc7.vec_cnt, ifc7.err_mask}),
                 32'(exp7_q.pop_front()));
    end
    done4_prev = ifc4.done;
    done7_prev = ifc7.done;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    sel = 0; idle();
    sel = 1; idle();
    #2;
    check("reset_out4", 32'({ifc4.in_ready, ifc4.done, ifc4.pass, ifc4.err_cnt,
                             ifc4.vec_cnt, ifc4.err_mask, dbg4}), 32'd0);
    check("reset_out7", 32'({ifc7.in_ready, ifc7.done, ifc7.pass, ifc7.err_cnt,
                             ifc7.vec_cnt, ifc7.err_mask, dbg7}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Vectors in IDLE are dropped
    sel = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, G11);
      @(negedge clk);
    end
    idle();
    check("idle_drop_vec", 32'(ifc4.vec_cnt), 32'd0);
    check("idle_drop_state", 32'({dbg4, ifc4.in_ready}), 32'd0);

    // Run A: four correct vectors streamed, full coverage
    exp4_q.push_back(pk(1'b1, 4'd0, 3'd4, 7'd0));
    do_start();
    check("run_ready", 32'(ifc4.in_ready), 32'd1);
    send_vec(1'b0, 1'b0, G00);
    send_vec(1'b0, 1'b1, G01);
    send_vec(1'b1, 1'b0, G10);
    check("not_done_early", 32'(ifc4.done), 32'd0);
    send_vec(1'b1, 1'b1, G11);
    idle();
    check("done_latency", 32'(ifc4.done), 32'd1);

    // Run B: start ignored mid-run, last vector has XOR stuck at 1
    exp4_q.push_back(pk(1'b0, 4'd1, 3'd4, 7'b0010000));
    do_start();
    send_vec(1'b0, 1'b0, G00);
    send_vec(1'b0, 1'b1, G01);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
    @(negedge clk);
    idle();
    @(negedge clk);
    check("start_in_run_cnt", 32'(ifc4.vec_cnt), 32'd2);
    check("start_in_run_state", 32'(dbg4), 32'd1);
    send_vec(1'b1, 1'b0, G10);
    send_vec(1'b1, 1'b1, 7'b1111000);
    idle();
    @(negedge clk);
    check("done_hold_cnt", 32'({ifc4.err_cnt, ifc4.vec_cnt}), 32'({4'd1, 3'd4}));

    // Run C: start+in_valid in DONE takes only the start; coverage hole
    exp4_q.push_back(pk(1'b0, 4'd0, 3'd4, 7'd0));
    drive(1'b1, 1'b1, 1'b0, 1'b0, G00);
    @(negedge clk);
    check("start_wins_cnt", 32'(ifc4.vec_cnt), 32'd0);
    check("start_wins_ready", 32'(ifc4.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) send_vec(1'b0, 1'b0, G00);
    idle();
    @(negedge clk);

    // Reset mid-run, then a normal run
    do_start();
    send_vec(1'b0, 1'b0, G00);
    send_vec(1'b1, 1'b1, 7'b0000000);
    idle();
    check("pre_reset_cnt", 32'({ifc4.err_cnt, ifc4.vec_cnt}), 32'({4'd1, 3'd2}));
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_out", 32'({ifc4.in_ready, ifc4.done, ifc4.pass, ifc4.err_cnt,
                                  ifc4.vec_cnt, ifc4.err_mask, dbg4}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp4_q.push_back(pk(1'b1, 4'd0, 3'd4, 7'd0));
    do_start();
    send_vec(1'b1, 1'b1, G11);
    send_vec(1'b1, 1'b0, G10);
    send_vec(1'b0, 1'b1, G01);
    send_vec(1'b0, 1'b0, G00);
    idle();
    @(negedge clk);

    // NUM_VEC=7: seven erroneous vectors, then a clean second run
    sel = 1;
    exp7_q.push_back(pk(1'b0, 4'd7, 3'd7, 7'b1011101));
    do_start();
    send_vec(1'b0, 1'b0, 7'b0001110);
    send_vec(1'b0, 1'b1, 7'b1110110);
    send_vec(1'b1, 1'b0, 7'b0100101);
    send_vec(1'b1, 1'b1, 7'b1100100);
    send_vec(1'b0, 1'b0, 7'b0011111);
    send_vec(1'b0, 1'b1, 7'b0110111);
    send_vec(1'b1, 1'b0, 7'b0111101);
    idle();
    @(negedge clk);
    exp7_q.push_back(pk(1'b1, 4'd0, 3'd7, 7'd0));
    do_start();
    check("second_run_clear", 32'({ifc7.err_cnt, ifc7.vec_cnt, ifc7.err_mask, ifc7.done}), 32'd0);
    send_vec(1'b0, 1'b0, G00);
    send_vec(1'b0, 1'b1, G01);
    send_vec(1'b1, 1'b0, G10);
    send_vec(1'b1, 1'b1, G11);
    send_vec(1'b0, 1'b0, G00);
    send_vec(1'b0, 1'b1, G01);
    send_vec(1'b1, 1'b0, G10);
    idle();

    repeat (3) @(negedge clk);
    check("exp4_drained", 32'(exp4_q.size()), 32'd0);
    check("exp7_drained", 32'(exp7_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
